// File: rtl/lsu_mem_requester.sv
// lsu_mem_requester: one-at-a-time RISC-V load/store unit driving a word-addressed memory port
module lsu_mem_requester #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_dout
);
  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;
  state_t state, nxt;
  logic              is_store_q, err_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, merge_q, rdata_q;
  logic              bad_f3, misal, bad, mem_st;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [DATA_W-1:0] ld_val, mask, lane, merged;

  always_comb begin
    bad_f3 = req_is_store ? (req_funct3[2] | (&req_funct3[1:0]))
                          : ((&req_funct3[1:0]) | (req_funct3[2] & req_funct3[1]));
    misal  = ((req_funct3[1:0] == 2'b01) & req_addr[0]) | ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0]));
    bad    = bad_f3 | misal;
  end

  // Load lane extraction; funct3[2] selects zero extension
  always_comb begin
    ld_b   = mem_dout[{addr_q[1:0], 3'b000} +: 8];
    ld_h   = addr_q[1] ? mem_dout[31:16] : mem_dout[15:0];
    ld_val = (f3_q[1:0] == 2'b00) ? {{24{~f3_q[2] & ld_b[7]}}, ld_b} :
             (f3_q[1:0] == 2'b01) ? {{16{~f3_q[2] & ld_h[15]}}, ld_h} : mem_dout;
    mask   = f3_q[0] ? (addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : (32'h0000_00FF << {addr_q[1:0], 3'b000});
    lane   = f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
    merged = (merge_q & ~mask) | (lane & mask);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = !req_valid ? IDLE : bad ? RESP : !req_is_store ? LOAD : (req_funct3 == 3'b010) ? STORE : RMW_RD;
      LOAD:    nxt = RESP;
      STORE:   nxt = RESP;
      RMW_RD:  nxt = RMW_WR;
      RMW_WR:  nxt = RESP;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_st     = state inside {LOAD, STORE, RMW_RD, RMW_WR};
    req_ready  = state == IDLE;
    resp_valid = state == RESP;
    resp_err   = resp_valid & err_q;
    resp_rdata = rdata_q;
    mem_read   = state inside {LOAD, RMW_RD};
    mem_write  = state inside {STORE, RMW_WR};
    mem_addr   = mem_st ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_din    = (state == STORE) ? wdata_q : (state == RMW_WR) ? merged : '0;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      is_store_q <= 1'b0;
      err_q      <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      rdata_q    <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        is_store_q <= req_is_store;
        f3_q       <= req_funct3;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        err_q      <= bad;
        if (bad) rdata_q <= '0;
      end
      if (state inside {LOAD, STORE, RMW_WR}) rdata_q <= is_store_q ? '0 : ld_val;
      if (state == RMW_RD) merge_q <= mem_dout;
    end
endmodule

// File: tb/tb_lsu_mem_requester.sv
// tb_lsu_mem_requester: scoreboard bench with directed load/store vectors and a behavioural memory
module tb_lsu_mem_requester;
  logic        clk = 0, reset = 1;
  logic        req_valid = 0, req_ready, req_is_store = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_din, mem_dout;
  logic [31:0] mem [0:255];

  typedef struct {logic [31:0] rdata; logic err; int lat; int nrd; int nwr; logic [31:0] din;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_err = 0, cyc = 0, acc = 0, rd = 0, wr = 0, wr_total = 0;
  logic [31:0] last_din = 0;

  lsu_mem_requester dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_read(mem_read), .mem_write(mem_write), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;
  assign mem_dout = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_din;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic e, input int l, input int nr, input int nw, input logic [31:0] d);
    exp_t x;
    x.rdata = r; x.err = e; x.lat = l; x.nrd = nr; x.nwr = nw; x.din = d;
    return x;
  endfunction

  always @(negedge clk) begin
    wr_total += int'(mem_write);
    if (reset) begin
      rd = 0;
      wr = 0;
    end else begin
      if (mem_read) rd++;
      if (mem_write) begin
        wr++;
        last_din = mem_din;
      end
      if (resp_valid) begin
        if (q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("rdata", resp_rdata, e.rdata);
          chk("err", {31'd0, resp_err}, {31'd0, e.err});
          chk("latency", cyc - acc, e.lat);
          chk("reads", rd, e.nrd);
          chk("writes", wr, e.nwr);
          if (e.nwr != 0) chk("mem_din", last_din, e.din);
        end
      end
      if (req_valid && req_ready) begin
        acc = cyc;
        rd = 0;
        wr = 0;
      end
    end
    cyc++;
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input logic push, input exp_t e);
    int n = 0;
    req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1;
    if (push) q.push_back(e);
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run1(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input exp_t e);
    int n = 0;
    issue(st, f3, a, wd, 1'b1, e);
    req_valid = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      chk("resp_timeout", 32'd1, 32'd0);
      q.delete();
    end
  endtask

  initial begin
    exp_t z;
    z = mk(0, 0, 0, 0, 0, 0);
    foreach (mem[i]) mem[i] = 32'h0;
    mem[8'h40] = 32'hDEADBEEF;
    mem[8'h80] = 32'h80FF7F01;
    mem[8'hC0] = 32'hAABBCCDD;
    mem[8'hE0] = 32'h0BADF00D;
    #3;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_outs", {28'd0, resp_valid, resp_err, mem_read, mem_write}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    run1(0, 3'b010, 32'h100, 0, mk(32'hDEADBEEF, 0, 2, 1, 0, 0));
    run1(1, 3'b010, 32'h104, 32'h12345678, mk(0, 0, 2, 0, 1, 32'h12345678));
    chk("mem_104", mem[8'h41], 32'h12345678);
    run1(0, 3'b000, 32'h202, 0, mk(32'hFFFFFFFF, 0, 2, 1, 0, 0));
    run1(0, 3'b100, 32'h203, 0, mk(32'h00000080, 0, 2, 1, 0, 0));
    run1(0, 3'b001, 32'h202, 0, mk(32'hFFFF80FF, 0, 2, 1, 0, 0));
    run1(0, 3'b101, 32'h200, 0, mk(32'h00007F01, 0, 2, 1, 0, 0));
    run1(1, 3'b000, 32'h301, 32'hA5A5A511, mk(0, 0, 3, 1, 1, 32'hAABB11DD));
    run1(1, 3'b001, 32'h302, 32'h99995566, mk(0, 0, 3, 1, 1, 32'h556611DD));
    chk("mem_300", mem[8'hC0], 32'h556611DD);
    run1(0, 3'b010, 32'h101, 0, mk(0, 1, 1, 0, 0, 0));
    run1(1, 3'b001, 32'h303, 32'hFFFF, mk(0, 1, 1, 0, 0, 0));
    run1(0, 3'b011, 32'h100, 0, mk(0, 1, 1, 0, 0, 0));
    run1(1, 3'b100, 32'h100, 32'h1, mk(0, 1, 1, 0, 0, 0));
    run1(0, 3'b110, 32'h100, 0, mk(0, 1, 1, 0, 0, 0));
    chk("mem_100_kept", mem[8'h40], 32'hDEADBEEF);
    // Back-to-back: valid stays high, each request waits for req_ready
    issue(0, 3'b010, 32'h100, 0, 1'b1, mk(32'hDEADBEEF, 0, 2, 1, 0, 0));
    issue(1, 3'b000, 32'h200, 32'h44, 1'b1, mk(0, 0, 3, 1, 1, 32'h80FF7F44));
    issue(0, 3'b010, 32'h200, 0, 1'b1, mk(32'h80FF7F44, 0, 2, 1, 0, 0));
    run1(1, 3'b000, 32'h203, 32'h55, mk(0, 0, 3, 1, 1, 32'h55FF7F44));
    chk("mem_200", mem[8'h80], 32'h55FF7F44);
    // Reset during RMW_RD must abort the write
    begin
      int w0;
      w0 = wr_total;
      issue(1, 3'b000, 32'h381, 32'h77, 1'b0, z);
      req_valid = 0;
      chk("rmw_rd_state", {30'd0, mem_read, req_ready}, 32'd2);
      reset = 1;
      #1;
      chk("async_ready", {31'd0, req_ready}, 32'd1);
      chk("async_wr", {30'd0, mem_write, mem_read}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_no_write", wr_total - w0, 32'd0);
      chk("mem_380", mem[8'hE0], 32'h0BADF00D);
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    end
    run1(0, 3'b000, 32'h381, 0, mk(32'hFFFFFFF0, 0, 2, 1, 0, 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
